gpio_mulpop_engine: RTL

- Parametrised, bus-mapped multiply + popcount coprocessor for the GPIO emulator platform.
- Host writes two operands, starts the operation, polls status, then reads the product and its ones-count.
- Multiplication is sequential shift-add, one multiplier bit per clock.
- All bus strobes are sampled on clk; a completed-operation counter is driven onto gpio_out.

---
 rtl/gpio_mulpop_engine_if.sv | 19 +
 rtl/gpio_mulpop_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gpio_mulpop_engine_if.sv
// Host bus bundle for the multiply/popcount coprocessor.
// The host drives address, strobes and write data; the engine returns read data.
interface gpio_mulpop_engine_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (
    output saddress, srd, swr, sdata_in,
    input  sdata_out
  );

  modport slave (
    input  saddress, srd, swr, sdata_in,
    output sdata_out
  );
endinterface

// File: rtl/gpio_mulpop_engine.sv
// Bus-mapped sequential shift-add multiplier with popcount of the result.
// Completed-operation counter is exported on gpio_out.
module gpio_mulpop_engine #(
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] ADDR_A1   = 16'h0380,
  parameter logic [15:0] ADDR_A2   = 16'h0388,
  parameter logic [15:0] ADDR_W    = 16'h0390,
  parameter logic [15:0] ADDR_L    = 16'h0398,
  parameter logic [15:0] ADDR_CS   = 16'h03A0,
  parameter logic [15:0] ADDR_GPIN = 16'h03A8
) (
  input  logic        clk,
  input  logic        n_reset,
  gpio_mulpop_engine_if.slave bus,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int AW = 2 * OP_W;
  localparam int LW = $clog2(RES_W + 1);
  localparam int IW = $clog2(OP_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_POP,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic             r_srd_q, r_swr_q, r_lat_q;
  logic [OP_W-1:0]  r_a1, r_a2, r_mplier;
  logic [RES_W-1:0] r_w;
  logic [LW-1:0]    r_l;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done, r_valid;
  logic [AW-1:0]    r_acc, r_mcand;
  logic [IW-1:0]    r_idx;
  logic [31:0]      r_gpin, r_rdata;

  logic             w_rd_ev, w_wr_ev, w_lat_ev;
  logic             w_cs_wr, w_clr, w_start, w_last, w_hi_zero;
  logic [RES_W-1:0] w_res;
  logic [LW-1:0]    w_pop;
  logic [31:0]      w_rmux;
  logic             w_unused;

  assign w_rd_ev  = bus.srd & ~r_srd_q;
  assign w_wr_ev  = bus.swr & ~r_swr_q;
  assign w_lat_ev = gpio_latch & ~r_lat_q;
  assign w_cs_wr  = w_wr_ev & (bus.saddress == ADDR_CS);
  assign w_clr    = w_cs_wr & bus.sdata_in[31];
  assign w_start  = w_cs_wr & ~bus.sdata_in[31]
                  & (r_state == S_IDLE);
  assign w_last   = (r_idx == IW'(OP_W - 1));
  assign w_res    = r_acc[RES_W-1:0];
  // Shifting by RES_W yields zero when the product fits exactly.
  assign w_hi_zero = ((r_acc >> RES_W) == '0);
  assign w_unused  = ^bus.sdata_in;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < RES_W; k++)
      w_pop = w_pop + LW'(w_res[k]);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_MULT;
      S_MULT: if (w_last) w_next = S_POP;
      S_POP:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rmux = '0;
    unique case (1'b1)
      (bus.saddress == ADDR_A1):   w_rmux = 32'(r_a1);
      (bus.saddress == ADDR_A2):   w_rmux = 32'(r_a2);
      (bus.saddress == ADDR_W):    w_rmux = r_done ? 32'(r_w) : '0;
      (bus.saddress == ADDR_L):    w_rmux = 32'(r_l);
      (bus.saddress == ADDR_CS):   w_rmux = {29'b0, r_busy, r_done, r_valid};
      (bus.saddress == ADDR_GPIN): w_rmux = r_gpin;
      default:                     w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_srd_q  <= 1'b0;
      r_swr_q  <= 1'b0;
      r_lat_q  <= 1'b0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_mplier <= '0;
      r_w      <= '0;
      r_l      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_idx    <= '0;
      r_gpin   <= '0;
      r_rdata  <= '0;
    end else begin
      r_srd_q <= bus.srd;
      r_swr_q <= bus.swr;
      r_lat_q <= gpio_latch;
      if (w_rd_ev)  r_rdata <= w_rmux;
      if (w_lat_ev) r_gpin  <= gpio_in;
      if (w_wr_ev && !r_busy && bus.saddress == ADDR_A1)
        r_a1 <= bus.sdata_in[OP_W-1:0];
      if (w_wr_ev && !r_busy && bus.saddress == ADDR_A2)
        r_a2 <= bus.sdata_in[OP_W-1:0];
      unique case (r_state)
        S_IDLE: if (w_start) begin
          r_busy   <= 1'b1;
          r_done   <= 1'b0;
          r_valid  <= 1'b0;
          r_acc    <= '0;
          r_mcand  <= AW'(r_a1);
          r_mplier <= r_a2;
          r_idx    <= '0;
        end
        S_MULT: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_idx    <= r_idx + IW'(1);
        end
        S_POP: begin
          r_w     <= w_res;
          r_l     <= w_pop;
          r_valid <= w_hi_zero;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
      // Soft clear overrides a completion landing on the same edge.
      if (w_clr) begin
        r_cnt   <= '0;
        r_done  <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.sdata_out   = r_rdata;
  assign gpio_out        = 32'(r_cnt);
  assign gpio_in_s_insp  = r_gpin;

endmodule
